// File: rtl/game_input_ctrl_pkg.sv
// Shared definitions for the game input controller: default timing values
// and the shoot-FSM state encoding.
package game_input_ctrl_pkg;

  localparam int DEF_CLK_DIV        = 833334;
  localparam int DEF_DB_CYCLES      = 500000;
  localparam int DEF_SHOOT_COOLDOWN = 12;

  typedef enum logic [1:0] {
    READY = 2'b00,
    FIRE  = 2'b01,
    COOL  = 2'b10
  } shoot_state_t;

  // Bits needed to hold 0..max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchronizer, polarity inversion and a
// hold-time debouncer producing an active-high debounced level.
module btn_debounce
  import game_input_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic btn_raw,
  output logic level
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_a;
  logic          sync_b;
  logic          pressed;
  logic [CW-1:0] cnt;

  // Synchronizer flops rest at 1, the released state of an active-low button.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  assign pressed = ~sync_b;

  // Any cycle that agrees with the current level restarts the hold timer,
  // so only an uninterrupted run of DB_CYCLES cycles flips the level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (pressed == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= pressed;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Game input controller: tick generator, debounced buttons, move requests,
// start/stop pulser and a rate-limited shoot FSM, all updated on tick fall.
module game_input_ctrl
  import game_input_ctrl_pkg::*;
#(
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int DB_CYCLES      = DEF_DB_CYCLES,
  parameter int SHOOT_COOLDOWN = DEF_SHOOT_COOLDOWN
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_BtnLeft,
  input  logic i_BtnRight,
  input  logic i_BtnShoot,
  input  logic i_BtnStart,
  input  logic i_GameActive,
  output logic o_Tick,
  output logic o_PlayerMoveLeft,
  output logic o_PlayerMoveRight,
  output logic o_PlayerBulletShoot,
  output logic o_GameStartStop
);

  localparam int             TW        = cnt_width(CLK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]  TICK_HALF = TW'(CLK_DIV / 2);
  localparam logic [TW-1:0]  TICK_ONE  = TW'(1);

  localparam int             CCW       = cnt_width(SHOOT_COOLDOWN);
  localparam logic [CCW-1:0] COOL_LOAD = CCW'(SHOOT_COOLDOWN - 1);
  localparam logic [CCW-1:0] COOL_ONE  = CCW'(1);

  logic [TW-1:0]  tick_cnt;
  logic           update;

  logic           db_left;
  logic           db_right;
  logic           db_shoot;
  logic           db_start;

  logic           start_q;
  logic           start_rise;
  logic           start_pending;

  shoot_state_t   state;
  shoot_state_t   state_next;
  logic [CCW-1:0] cool_cnt;
  logic [CCW-1:0] cool_next;

  // o_Tick is a registered compare, so it rises on the first edge after reset.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tick_cnt <= '0;
      o_Tick   <= 1'b0;
    end else begin
      o_Tick   <= (tick_cnt < TICK_HALF);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_ONE;
    end
  end

  // The edge that takes o_Tick from 1 to 0 is where all game outputs move.
  assign update = (tick_cnt == TICK_HALF);

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .btn_raw (i_BtnLeft),
    .level   (db_left)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .btn_raw (i_BtnRight),
    .level   (db_right)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_shoot (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .btn_raw (i_BtnShoot),
    .level   (db_shoot)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .btn_raw (i_BtnStart),
    .level   (db_start)
  );

  // Opposing directions cancel so the player never gets a conflicting request.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_PlayerMoveLeft  <= 1'b0;
      o_PlayerMoveRight <= 1'b0;
    end else if (update) begin
      o_PlayerMoveLeft  <= db_left & ~db_right;
      o_PlayerMoveRight <= db_right & ~db_left;
    end
  end

  assign start_rise = db_start & ~start_q;

  // A press landing on the update edge itself is folded straight into the pulse.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      start_q         <= 1'b0;
      start_pending   <= 1'b0;
      o_GameStartStop <= 1'b0;
    end else begin
      start_q <= db_start;
      if (update) begin
        o_GameStartStop <= start_pending | start_rise;
        start_pending   <= 1'b0;
      end else if (start_rise) begin
        start_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= READY;
      cool_cnt <= '0;
    end else begin
      state    <= state_next;
      cool_cnt <= cool_next;
    end
  end

  // Leaving the game at any update edge abandons a shot or cooldown in progress.
  always_comb begin
    state_next = state;
    cool_next  = cool_cnt;
    if (update) begin
      if (!i_GameActive) begin
        state_next = READY;
        cool_next  = '0;
      end else begin
        case (state)
          READY: begin
            if (db_shoot) state_next = FIRE;
          end
          FIRE: begin
            state_next = COOL;
            cool_next  = COOL_LOAD;
          end
          COOL: begin
            if (cool_cnt == '0) begin
              state_next = db_shoot ? FIRE : READY;
            end else begin
              cool_next = cool_cnt - COOL_ONE;
            end
          end
          default: begin
            state_next = READY;
            cool_next  = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    o_PlayerBulletShoot = 1'b0;
    if (state == FIRE) o_PlayerBulletShoot = 1'b1;
  end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl: expected per-tick outputs are queued
// as stimulus is applied and compared at each o_Tick rising edge.
module tb_game_input_ctrl;

  localparam int CLK_DIV        = 4;
  localparam int DB_CYCLES      = 3;
  localparam int SHOOT_COOLDOWN = 3;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] LEFT = 4'b1000;
  localparam logic [3:0] RGHT = 4'b0100;
  localparam logic [3:0] SHOT = 4'b0010;
  localparam logic [3:0] STRT = 4'b0001;

  logic clock = 1'b0;
  logic reset;
  logic btnLeft;
  logic btnRight;
  logic btnShoot;
  logic btnStart;
  logic gameActive;
  logic tick;
  logic moveLeft;
  logic moveRight;
  logic bulletShoot;
  logic startStop;

  int errors = 0;
  int checks = 0;
  logic [3:0] expQueue[$];

  always #5 clock = ~clock;

  game_input_ctrl #(
    .CLK_DIV        (CLK_DIV),
    .DB_CYCLES      (DB_CYCLES),
    .SHOOT_COOLDOWN (SHOOT_COOLDOWN)
  ) dut (
    .i_Clock             (clock),
    .i_Reset             (reset),
    .i_BtnLeft           (btnLeft),
    .i_BtnRight          (btnRight),
    .i_BtnShoot          (btnShoot),
    .i_BtnStart          (btnStart),
    .i_GameActive        (gameActive),
    .o_Tick              (tick),
    .o_PlayerMoveLeft    (moveLeft),
    .o_PlayerMoveRight   (moveRight),
    .o_PlayerBulletShoot (bulletShoot),
    .o_GameStartStop     (startStop)
  );

  function automatic logic [3:0] outVec();
    return {moveLeft, moveRight, bulletShoot, startStop};
  endfunction

  // Arguments are "pressed" flags; the pins themselves are active-low.
  task automatic applyStimulus(input bit left, input bit right, input bit shoot,
                               input bit start, input bit active);
    btnLeft    = ~left;
    btnRight   = ~right;
    btnShoot   = ~shoot;
    btnStart   = ~start;
    gameActive = active;
  endtask

  task automatic pushExp(input logic [3:0] value);
    expQueue.push_back(value);
  endtask

  task automatic checkValue(input string tag, input logic [3:0] observed,
                            input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic waitRise(output bit ok);
    logic prev;
    prev = tick;
    ok   = 1'b0;
    for (int c = 0; c < 3 * CLK_DIV; c++) begin
      @(negedge clock);
      if (tick === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = tick;
    end
  endtask

  // Waits for n tick rising edges and compares outputs with queued values.
  task automatic checkOutput(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      bit ok;
      logic [3:0] expected;
      waitRise(ok);
      checks++;
      assert (ok) else begin
        errors++;
        $error("[TB] FAIL %s_timeout: observed=no_tick_rise expected=tick_rise", tag);
      end
      if (expQueue.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL %s_queue: observed=empty expected=entry", tag);
      end else begin
        expected = expQueue.pop_front();
        checkValue(tag, outVec(), expected);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] tickExp;

    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkValue("reset_tick", {3'b000, tick}, 4'b0000);
    checkValue("reset_outputs", outVec(), NONE);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      tickExp = ((i % 4) < 2) ? 4'b0001 : 4'b0000;
      checkValue("tick_pattern", {3'b000, tick}, tickExp);
    end

    repeat (20) pushExp(NONE);
    checkOutput("idle", 20);

    $display("[TB] left glitch of two cycles");
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (4) pushExp(NONE);
    checkOutput("left_glitch", 4);

    $display("[TB] left held, then right added");
    applyStimulus(1, 0, 0, 0, 0);
    pushExp(NONE); pushExp(LEFT); pushExp(LEFT);
    checkOutput("left_hold", 3);
    applyStimulus(1, 1, 0, 0, 0);
    pushExp(LEFT); pushExp(NONE); pushExp(NONE);
    checkOutput("both_pressed", 3);
    applyStimulus(0, 0, 0, 0, 0);
    pushExp(NONE); pushExp(NONE);
    checkOutput("both_release", 2);
    applyStimulus(0, 1, 0, 0, 0);
    pushExp(NONE); pushExp(RGHT); pushExp(RGHT);
    checkOutput("right_hold", 3);
    applyStimulus(0, 0, 0, 0, 0);
    pushExp(RGHT); pushExp(NONE);
    checkOutput("right_release", 2);

    $display("[TB] shoot held with game active");
    applyStimulus(0, 0, 0, 0, 1);
    pushExp(NONE);
    checkOutput("active_idle", 1);
    applyStimulus(0, 0, 1, 0, 1);
    for (int j = 1; j <= 12; j++) pushExp((j == 2 || j == 6 || j == 10) ? SHOT : NONE);
    checkOutput("shoot_hold", 12);
    applyStimulus(0, 0, 0, 0, 1);
    pushExp(NONE); pushExp(NONE);
    checkOutput("shoot_release", 2);

    $display("[TB] shoot held with game inactive");
    applyStimulus(0, 0, 1, 0, 0);
    repeat (4) pushExp(NONE);
    checkOutput("shoot_inactive", 4);
    applyStimulus(0, 0, 1, 0, 1);
    pushExp(SHOT);
    checkOutput("shoot_on_activate", 1);
    pushExp(NONE);
    checkOutput("shoot_cool", 1);
    applyStimulus(0, 0, 1, 0, 0);
    pushExp(NONE);
    checkOutput("cool_abort", 1);
    applyStimulus(0, 0, 1, 0, 1);
    pushExp(SHOT);
    checkOutput("shoot_after_abort", 1);
    applyStimulus(0, 0, 0, 0, 0);
    pushExp(NONE); pushExp(NONE);
    checkOutput("shoot_idle", 2);

    $display("[TB] start pressed twice within one tick");
    applyStimulus(0, 0, 0, 1, 1);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 1);
    @(negedge clock);
    applyStimulus(0, 0, 0, 1, 1);
    pushExp(NONE); pushExp(NONE); pushExp(STRT); pushExp(NONE); pushExp(NONE);
    checkOutput("start_double", 5);
    applyStimulus(0, 0, 0, 0, 1);
    pushExp(NONE); pushExp(NONE);
    checkOutput("start_release", 2);
    applyStimulus(0, 0, 0, 1, 1);
    pushExp(NONE); pushExp(STRT); pushExp(NONE);
    checkOutput("start_single", 3);
    applyStimulus(0, 0, 0, 0, 1);
    pushExp(NONE);
    checkOutput("start_release2", 1);

    $display("[TB] reset during FIRE");
    applyStimulus(0, 0, 1, 0, 1);
    pushExp(NONE); pushExp(SHOT);
    checkOutput("fire_before_reset", 2);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    #1;
    checkValue("reset_mid_fire", outVec(), NONE);
    checkValue("reset_mid_fire_tick", {3'b000, tick}, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkValue("first_tick_after_reset", {3'b000, tick}, 4'b0001);
    repeat (5) pushExp(NONE);
    checkOutput("after_reset_quiet", 5);
    applyStimulus(0, 0, 1, 0, 1);
    pushExp(NONE); pushExp(SHOT); pushExp(NONE);
    checkOutput("new_press_after_reset", 3);
    applyStimulus(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
